instr_issue_queue: RTL and testbench
====================================

Name: instr_issue_queue

Overview:
- Upstream stage of the TPU top level.
- Accepts 16-bit instructions from the host over a valid/ready handshake and buffers them in a FIFO.
- Issues at most one instruction per cycle on a registered `instruction` bus, which drives the control unit's instruction input.
- Executes two sequencing opcodes (WAIT, HALT) locally. These let the host pace load/compute phases without cycle-exact feeding.

Parameters:
- DEPTH, 8: FIFO entries; power of two, ≥2.
- IW, 16: instruction width.
- AW, 13: operand/address field width (instr[12:0]).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  single-cycle pulse; leaves IDLE/HALTED
- in_valid  input  1  host instruction valid
- in_instr  input  16  host instruction
- in_ready  output  1  FIFO can accept (= !full)
- instruction  output  16  issued instruction to the control unit; 16'h0000 = NOP
- busy  output  1  state is RUN or WAIT
- halted  output  1  state is HALTED
- fifo_count  output  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset/clocking: one clock, clk. Reset is synchronous and active-high. Reset takes priority over every other input, including in the middle of a WAIT.
- Reset values: FIFO empty, state IDLE, instruction=0, busy=0, halted=0, fifo_count=0, wait counter=0, in_ready=1.
- Instruction format: opcode=instr[15:13], operand=instr[12:0].
  - 3'b110 = HALT.
  - 3'b111 = WAIT.
  - 3'b000 = NOP.
  - All other opcodes are forwarded unchanged.
- Push: occurs when in_valid && in_ready at a rising edge. in_ready = (fifo_count != DEPTH), combinational from registered count. When full, the push is refused even if a pop happens in the same cycle (no full-bypass).
- Pop and issue: the output register loads on the edge after the pop decision. No empty-bypass: an instruction pushed at edge t is visible on `instruction` after edge t+1 at the earliest.
- Simultaneous push and pop on a non-full, non-empty FIFO: count is unchanged and both pointers advance. Pointers wrap modulo DEPTH.
- FSM states: IDLE, RUN, WAIT, HALTED.
  - IDLE: instruction=0; no pops; pushes are allowed. start → RUN.
  - RUN, FIFO empty: instruction=0; stay in RUN.
  - RUN, FIFO non-empty: pop the head. Then:
    - Normal opcode: instruction=head.
    - WAIT: instruction=0; if operand==0, stay in RUN; else load counter=operand and go to WAIT.
    - HALT: instruction=0; go to HALTED.
  - WAIT: instruction=0; counter decrements each cycle; when counter==1, return to RUN. A WAIT with operand N therefore yields exactly N+1 NOP cycles in total, including the WAIT's own issue slot.
  - HALTED: instruction=0; pushes still accepted; start → RUN. start in RUN/WAIT is ignored.
- Issue cadence: each pop issues for exactly one cycle. The next pop may occur on the very next cycle, giving back-to-back issue with no bubbles.

Optional Feature:
- Macro: IQ_PERF_CNT_EN.
- When defined: adds output port issued_count [31:0].
  - Counts instructions popped while in RUN, all opcodes included.
  - Cleared on reset; wraps at 2^32.
- When undefined: the port and its counter logic are absent; all other behaviour is identical.

Decomposition:
- Shared package tpu_isa_pkg:
  - opcode enum (NOP, HALT, WAIT and the forwarded opcodes);
  - IW/AW constants;
  - OPC_MSB/OPC_LSB field positions;
  - NOP_INSTR=16'h0000;
  - issue-state enum.
- Sub-module: sync_fifo (DEPTH, IW), providing push/pop/full/empty/count. The issue FSM lives in instr_issue_queue.

Test Plan:
- Reset then push 3 instrs (16'h2005, 16'h4003, 16'h6001) while in IDLE → instruction stays 0, fifo_count=3. Pulse start → the three values appear on consecutive cycles, then 0; busy=1 throughout.
- Push 9 instrs with DEPTH=8 and no start → in_ready drops after the 8th accept; the 9th holds until a pop. After start, it issues in order with no loss or duplication.
- RUN with a queue of 16'hE003 (WAIT 3) then 16'h2001 → 4 NOP cycles, then 16'h2001 issued. 16'hE000 → 1 NOP, then the next instruction immediately.
- Queue 16'h2001, 16'hC000 (HALT), 16'h4002 → 16'h2001 issued, then halted=1, busy=0, instruction=0 held indefinitely. Pulse start → 16'h4002 issued next.
- Assert reset mid-WAIT (counter=5) with 4 entries queued → next cycle: IDLE, fifo_count=0, instruction=0, halted=0; a subsequent start with an empty FIFO issues only NOPs.
- With IQ_PERF_CNT_EN defined: issue 5 instructions including one WAIT and one HALT → issued_count=5; reset → 0.

Source files
------------

// File: rtl/tpu_isa_pkg.sv
// tpu_isa_pkg: shared ISA field layout, opcodes and issue-queue state encoding
package tpu_isa_pkg;
    localparam int IW = 16;
    localparam int AW = 13;
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 13;
    localparam logic [IW-1:0] NOP_INSTR = 16'h0000;
    typedef enum logic [2:0] {
        OP_NOP     = 3'b000,
        OP_LOAD_W  = 3'b001,
        OP_LOAD_X  = 3'b010,
        OP_COMPUTE = 3'b011,
        OP_STORE   = 3'b100,
        OP_SYNC    = 3'b101,
        OP_HALT    = 3'b110,
        OP_WAIT    = 3'b111
    } opcode_t;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT, S_HALTED} issue_state_t;
endpackage

// File: rtl/instr_issue_queue_if.sv
// instr_issue_queue_if: host-to-queue instruction valid/ready handshake
interface instr_issue_queue_if #(parameter int IW = 16);
    logic in_valid;
    logic [IW-1:0] in_instr;
    logic in_ready;
    modport master(output in_valid, in_instr, input in_ready);
    modport slave(input in_valid, in_instr, output in_ready);
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO, push refused when full even alongside a pop
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int IW = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic pop,
    input  logic [IW-1:0] din,
    output logic [IW-1:0] dout,
    output logic full,
    output logic empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    logic [IW-1:0] mem [DEPTH];
    logic [PW-1:0] wp, rp;
    logic do_push, do_pop;
    assign full = count == (PW+1)'(DEPTH);
    assign empty = count == '0;
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    assign dout = mem[rp];
    always_ff @(posedge clk) begin
        if (reset) begin
            wp <= '0;
            rp <= '0;
            count <= '0;
        end else begin
            wp <= do_push ? wp + 1'b1 : wp;
            rp <= do_pop ? rp + 1'b1 : rp;
            count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk) if (do_push) mem[wp] <= din;
endmodule

// File: rtl/instr_issue_queue.sv
// instr_issue_queue: buffers host instructions and issues them, executing WAIT/HALT locally; IQ_PERF_CNT_EN adds issued_count
module instr_issue_queue #(
    parameter int DEPTH = 8,
    parameter int IW = 16,
    parameter int AW = 13
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    instr_issue_queue_if.slave host,
    output logic [IW-1:0] instruction,
    output logic busy,
    output logic halted,
    output logic [$clog2(DEPTH):0] fifo_count
`ifdef IQ_PERF_CNT_EN
    ,
    output logic [31:0] issued_count
`endif
);
    import tpu_isa_pkg::*;
    issue_state_t state, state_n;
    logic [AW-1:0] wcnt, wcnt_n;
    logic [IW-1:0] head, instr_n;
    logic empty, full, pop;
    opcode_t op;
    assign op = opcode_t'(head[OPC_MSB:OPC_LSB]);
    assign pop = state == S_RUN && !empty;
    assign host.in_ready = !full;
    assign busy = state == S_RUN || state == S_WAIT;
    assign halted = state == S_HALTED;
    sync_fifo #(.DEPTH(DEPTH), .IW(IW)) u_fifo (
        .clk(clk),
        .reset(reset),
        .push(host.in_valid),
        .pop(pop),
        .din(host.in_instr),
        .dout(head),
        .full(full),
        .empty(empty),
        .count(fifo_count)
    );
    always_comb begin
        state_n = state;
        wcnt_n = wcnt;
        instr_n = NOP_INSTR;
        case (state)
            S_IDLE, S_HALTED: state_n = start ? S_RUN : state;
            S_RUN: if (pop) begin
                if (op == OP_WAIT) begin
                    state_n = head[AW-1:0] != '0 ? S_WAIT : S_RUN;
                    wcnt_n = head[AW-1:0];
                end else if (op == OP_HALT) state_n = S_HALTED;
                else instr_n = head;
            end
            S_WAIT: begin
                wcnt_n = wcnt - 1'b1;
                state_n = wcnt == AW'(1) ? S_RUN : S_WAIT;
            end
            default: state_n = S_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            wcnt <= '0;
            instruction <= NOP_INSTR;
        end else begin
            state <= state_n;
            wcnt <= wcnt_n;
            instruction <= instr_n;
        end
    end
`ifdef IQ_PERF_CNT_EN
    always_ff @(posedge clk) issued_count <= reset ? '0 : issued_count + 32'(pop);
`endif
endmodule

// File: tb/tb_instr_issue_queue.sv
// tb_instr_issue_queue: directed and randomized checks of the issue queue against a rule-level model
module tb_instr_issue_queue;
    localparam int DEPTH = 8;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic [15:0] instruction;
    logic busy, halted;
    logic [3:0] fifo_count;
    int n_cmp = 0;
    int n_bad = 0;
`ifdef IQ_PERF_CNT_EN
    logic [31:0] issued_count;
`endif
    instr_issue_queue_if #(.IW(16)) host();
    always #5 clk = ~clk;
    instr_issue_queue #(.DEPTH(DEPTH), .IW(16), .AW(13)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .host(host),
        .instruction(instruction),
        .busy(busy),
        .halted(halted),
        .fifo_count(fifo_count)
`ifdef IQ_PERF_CNT_EN
        ,
        .issued_count(issued_count)
`endif
    );
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        host.in_valid = 1'b0;
        tick();
        reset = 1'b0;
    endtask
    task automatic push(input logic [15:0] v);
        host.in_valid = 1'b1;
        host.in_instr = v;
        tick();
        host.in_valid = 1'b0;
    endtask
    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask
    task automatic test_reset();
        do_reset();
        n_cmp++; if (instruction !== 16'h0) begin n_bad++; $display("FAIL reset_instr: got %h want 0000", instruction); end
        n_cmp++; if (busy !== 1'b0 || halted !== 1'b0) begin n_bad++; $display("FAIL reset_flags: got busy=%b halted=%b want 0/0", busy, halted); end
        n_cmp++; if (fifo_count !== 4'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        n_cmp++; if (host.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", host.in_ready); end
    endtask
    task automatic test_idle_queue();
        logic [15:0] exp [5] = '{16'h2005, 16'h4003, 16'h6001, 16'h0, 16'h0};
        do_reset();
        push(16'h2005);
        push(16'h4003);
        push(16'h6001);
        tick();
        n_cmp++; if (instruction !== 16'h0 || busy !== 1'b0) begin n_bad++; $display("FAIL idle_hold: got instr=%h busy=%b want 0000/0", instruction, busy); end
        n_cmp++; if (fifo_count !== 4'd3) begin n_bad++; $display("FAIL idle_count: got %0d want 3", fifo_count); end
        pulse_start();
        n_cmp++; if (instruction !== 16'h0 || busy !== 1'b1) begin n_bad++; $display("FAIL idle_start: got instr=%h busy=%b want 0000/1", instruction, busy); end
        foreach (exp[k]) begin
            tick();
            n_cmp++; if (instruction !== exp[k] || busy !== 1'b1) begin n_bad++; $display("FAIL idle_issue%0d: got instr=%h busy=%b want %h/1", k, instruction, busy, exp[k]); end
        end
    endtask
    task automatic test_full();
        logic [15:0] got[$];
        logic rdy;
        do_reset();
        for (int i = 0; i < DEPTH; i++) push(16'h2000 | 16'(i));
        n_cmp++; if (fifo_count !== 4'd8 || host.in_ready !== 1'b0) begin n_bad++; $display("FAIL full_flag: got count=%0d ready=%b want 8/0", fifo_count, host.in_ready); end
        host.in_valid = 1'b1;
        host.in_instr = 16'h2008;
        repeat (3) tick();
        n_cmp++; if (fifo_count !== 4'd8) begin n_bad++; $display("FAIL full_hold: got count=%0d want 8", fifo_count); end
        start = 1'b1;
        for (int c = 0; c < 20; c++) begin
            rdy = host.in_ready;
            tick();
            start = 1'b0;
            if (rdy) host.in_valid = 1'b0;
            if (instruction !== 16'h0) got.push_back(instruction);
        end
        host.in_valid = 1'b0;
        n_cmp++; if (got.size() != 9) begin n_bad++; $display("FAIL full_total: got %0d issued want 9", got.size()); end
        foreach (got[k]) begin
            n_cmp++; if (got[k] !== (16'h2000 | 16'(k))) begin n_bad++; $display("FAIL full_order%0d: got %h want %h", k, got[k], 16'h2000 | 16'(k)); end
        end
        n_cmp++; if (fifo_count !== 4'd0) begin n_bad++; $display("FAIL full_drain: got count=%0d want 0", fifo_count); end
    endtask
    task automatic test_wait();
        logic [15:0] exp [8] = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h2001, 16'h0, 16'h3001, 16'h0};
        do_reset();
        push(16'hE003);
        push(16'h2001);
        push(16'hE000);
        push(16'h3001);
        pulse_start();
        foreach (exp[k]) begin
            tick();
            n_cmp++; if (instruction !== exp[k] || busy !== 1'b1) begin n_bad++; $display("FAIL wait_seq%0d: got instr=%h busy=%b want %h/1", k, instruction, busy, exp[k]); end
        end
    endtask
    task automatic test_halt();
        do_reset();
        push(16'h2001);
        push(16'hC000);
        push(16'h4002);
        pulse_start();
        tick();
        n_cmp++; if (instruction !== 16'h2001) begin n_bad++; $display("FAIL halt_pre: got %h want 2001", instruction); end
        repeat (6) begin
            tick();
            n_cmp++; if (instruction !== 16'h0 || halted !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL halt_hold: got instr=%h halted=%b busy=%b want 0000/1/0", instruction, halted, busy); end
        end
        n_cmp++; if (fifo_count !== 4'd1) begin n_bad++; $display("FAIL halt_count: got %0d want 1", fifo_count); end
        pulse_start();
        n_cmp++; if (busy !== 1'b1 || halted !== 1'b0 || instruction !== 16'h0) begin n_bad++; $display("FAIL halt_restart: got busy=%b halted=%b instr=%h want 1/0/0000", busy, halted, instruction); end
        tick();
        n_cmp++; if (instruction !== 16'h4002) begin n_bad++; $display("FAIL halt_resume: got %h want 4002", instruction); end
    endtask
    task automatic test_reset_mid_wait();
        do_reset();
        push(16'hE00A);
        push(16'h2001);
        push(16'h3002);
        push(16'h4003);
        push(16'h5004);
        pulse_start();
        repeat (6) tick();
        n_cmp++; if (busy !== 1'b1 || instruction !== 16'h0) begin n_bad++; $display("FAIL midwait_busy: got busy=%b instr=%h want 1/0000", busy, instruction); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++; if (busy !== 1'b0 || halted !== 1'b0 || instruction !== 16'h0 || fifo_count !== 4'd0) begin n_bad++; $display("FAIL midwait_reset: got busy=%b halted=%b instr=%h count=%0d want 0/0/0000/0", busy, halted, instruction, fifo_count); end
        pulse_start();
        repeat (6) begin
            tick();
            n_cmp++; if (instruction !== 16'h0 || fifo_count !== 4'd0) begin n_bad++; $display("FAIL midwait_empty: got instr=%h count=%0d want 0000/0", instruction, fifo_count); end
        end
    endtask
    task automatic test_random();
        logic [15:0] prog[$];
        logic [2:0] op;
        int n;
        for (int it = 0; it < 20; it++) begin
            prog.delete();
            do_reset();
            n = $urandom_range(1, DEPTH);
            for (int k = 0; k < n; k++) begin
                op = 3'($urandom_range(0, 7));
                prog.push_back({op, op == 3'b111 ? 13'($urandom_range(0, 4)) : op == 3'b000 ? 13'h0 : 13'($urandom_range(0, 8191))});
                push(prog[k]);
            end
            n_cmp++; if (fifo_count !== 4'(n)) begin n_bad++; $display("FAIL rnd_count: got %0d want %0d", fifo_count, n); end
            pulse_start();
            foreach (prog[k]) begin
                if (prog[k][15:13] == 3'b111) begin
                    repeat (int'(prog[k][12:0]) + 1) begin
                        tick();
                        n_cmp++; if (instruction !== 16'h0 || busy !== 1'b1) begin n_bad++; $display("FAIL rnd_wait: got instr=%h busy=%b want 0000/1 (op %h)", instruction, busy, prog[k]); end
                    end
                end else if (prog[k][15:13] == 3'b110) begin
                    tick();
                    n_cmp++; if (instruction !== 16'h0 || halted !== 1'b1) begin n_bad++; $display("FAIL rnd_halt: got instr=%h halted=%b want 0000/1", instruction, halted); end
                    pulse_start();
                end else begin
                    tick();
                    n_cmp++; if (instruction !== prog[k]) begin n_bad++; $display("FAIL rnd_issue: got %h want %h", instruction, prog[k]); end
                end
            end
            tick();
            n_cmp++; if (instruction !== 16'h0 || fifo_count !== 4'd0 || busy !== 1'b1) begin n_bad++; $display("FAIL rnd_tail: got instr=%h count=%0d busy=%b want 0000/0/1", instruction, fifo_count, busy); end
        end
    endtask
    task automatic test_back_to_back();
        logic [15:0] sent[$], got[$];
        int cyc[$];
        int acc;
        logic rdy, vld;
        do_reset();
        for (int i = 0; i < 24; i++) sent.push_back({3'($urandom_range(1, 5)), 13'($urandom)});
        for (int i = 0; i < DEPTH; i++) push(sent[i]);
        acc = DEPTH;
        pulse_start();
        for (int c = 0; c < 400 && got.size() < 24; c++) begin
            if (!host.in_valid && acc < 24 && $urandom_range(0, 1) == 1) begin
                host.in_valid = 1'b1;
                host.in_instr = sent[acc];
            end
            rdy = host.in_ready;
            vld = host.in_valid;
            tick();
            if (vld && rdy) begin
                acc++;
                host.in_valid = 1'b0;
            end
            if (instruction !== 16'h0) begin
                got.push_back(instruction);
                cyc.push_back(c);
            end
        end
        host.in_valid = 1'b0;
        n_cmp++; if (got.size() != 24) begin n_bad++; $display("FAIL b2b_total: got %0d issued want 24", got.size()); end
        foreach (got[k]) begin
            n_cmp++; if (got[k] !== sent[k]) begin n_bad++; $display("FAIL b2b_order%0d: got %h want %h", k, got[k], sent[k]); end
        end
        n_cmp++; if (cyc.size() < DEPTH || cyc[DEPTH-1] - cyc[0] != DEPTH - 1) begin n_bad++; $display("FAIL b2b_gapless: got span %0d want %0d", cyc.size() >= DEPTH ? cyc[DEPTH-1] - cyc[0] : -1, DEPTH - 1); end
        tick();
        n_cmp++; if (fifo_count !== 4'd0) begin n_bad++; $display("FAIL b2b_drain: got count=%0d want 0", fifo_count); end
    endtask
`ifdef IQ_PERF_CNT_EN
    task automatic test_perf();
        do_reset();
        n_cmp++; if (issued_count !== 32'd0) begin n_bad++; $display("FAIL perf_reset0: got %0d want 0", issued_count); end
        push(16'h2001);
        push(16'hE001);
        push(16'h3002);
        push(16'hC000);
        push(16'h4003);
        pulse_start();
        repeat (6) tick();
        n_cmp++; if (issued_count !== 32'd4) begin n_bad++; $display("FAIL perf_halted: got %0d want 4", issued_count); end
        pulse_start();
        repeat (3) tick();
        n_cmp++; if (issued_count !== 32'd5) begin n_bad++; $display("FAIL perf_total: got %0d want 5", issued_count); end
        do_reset();
        n_cmp++; if (issued_count !== 32'd0) begin n_bad++; $display("FAIL perf_clear: got %0d want 0", issued_count); end
    endtask
`endif
    initial begin
        host.in_valid = 1'b0;
        host.in_instr = 16'h0;
        test_reset();
        test_idle_queue();
        test_full();
        test_wait();
        test_halt();
        test_reset_mid_wait();
        test_random();
        test_back_to_back();
`ifdef IQ_PERF_CNT_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
